// File: rtl/sobel_stream_filter_if.sv
// rtl/sobel_stream_filter_if.sv - pixel-in / result-out stream handshakes for the Sobel filter
interface sobel_stream_filter_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_last;

  modport master (
    output in_valid, in_pixel, in_sof, out_ready,
    input  in_ready, out_valid, out_pixel, out_last
  );

  modport slave (
    input  in_valid, in_pixel, in_sof, out_ready,
    output in_ready, out_valid, out_pixel, out_last
  );
endinterface

// File: rtl/sobel_stream_filter.sv
// rtl/sobel_stream_filter.sv - streaming 3x3 Sobel filter with two line buffers
// Two-stage pipeline: window sums, then abs/mode/saturation; one global stall on out_ready.
module sobel_stream_filter #(
  parameter int IMG_W = 224,
  parameter int IMG_H = 224,
  parameter int PIX_W = 8,
  parameter int SHIFT = 3
) (
  input  logic             fclk,
  input  logic             rst_n,
  sobel_stream_filter_if.slave s,
  input  logic [1:0]       mode,
  input  logic [PIX_W+2:0] threshold
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GW = PIX_W + 4;
  localparam logic [GW-1:0] MAXV = GW'((1 << PIX_W) - 1);

  logic [RW-1:0]    row_q, row_d, row_cur;
  logic [CW-1:0]    col_q, col_d, col_cur;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] t0_q, m0_q, b0_q, t1_q, m1_q, b1_q;
  logic [PIX_W-1:0] top2, mid2, bot2;

  logic                 s1_valid_q, s1_last_q;
  logic [1:0]           s1_mode_q;
  logic signed [GW-1:0] s1_gx_q, s1_gy_q, gx_d, gy_d;
  logic [GW-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic [GW-1:0]        ax, ay, mag, sel, scaled;
  logic [PIX_W-1:0]     out_d;

  logic             out_valid_q, out_last_q;
  logic [PIX_W-1:0] out_pixel_q;
  logic             en, acc, emit, last_pix;

  assign en         = s.out_ready;
  assign s.in_ready = s.out_ready && rst_n;
  assign acc        = s.in_valid && s.in_ready;

  // in_sof resynchronises the position of the very pixel that carries it
  assign row_cur  = s.in_sof ? '0 : row_q;
  assign col_cur  = s.in_sof ? '0 : col_q;
  assign emit     = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
  assign last_pix = (row_cur == RW'(IMG_H - 1)) && (col_cur == CW'(IMG_W - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (acc) begin
      if (col_cur == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
  end

  // Newest window column: row r-2, row r-1 from the line buffers, row r live
  assign top2 = lb1_q[col_cur];
  assign mid2 = lb0_q[col_cur];
  assign bot2 = s.in_pixel;

  assign gx_pos = GW'(top2) + (GW'(mid2) << 1) + GW'(bot2);
  assign gx_neg = GW'(t0_q) + (GW'(m0_q) << 1) + GW'(b0_q);
  assign gy_pos = GW'(b0_q) + (GW'(b1_q) << 1) + GW'(bot2);
  assign gy_neg = GW'(t0_q) + (GW'(t1_q) << 1) + GW'(top2);
  assign gx_d   = gx_pos - gx_neg;
  assign gy_d   = gy_pos - gy_neg;

  assign ax     = s1_gx_q[GW-1] ? (~s1_gx_q + 1'b1) : s1_gx_q;
  assign ay     = s1_gy_q[GW-1] ? (~s1_gy_q + 1'b1) : s1_gy_q;
  assign mag    = ax + ay;

  always_comb begin
    sel = mag;
    case (s1_mode_q)
      2'd2:    sel = ax;
      2'd3:    sel = ay;
      default: sel = mag;
    endcase
    scaled = sel >> SHIFT;
    out_d  = (scaled > MAXV) ? '1 : scaled[PIX_W-1:0];
    if (s1_mode_q == 2'd1) begin
      out_d = (mag >= GW'(threshold)) ? '1 : '0;
    end
  end

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      mode_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      if (acc && s.in_sof) begin
        mode_q <= mode;
      end
      if (en) begin
        s1_valid_q  <= acc && emit;
        s1_last_q   <= acc && emit && last_pix;
        s1_mode_q   <= mode_q;
        out_valid_q <= s1_valid_q;
        out_last_q  <= s1_valid_q && s1_last_q;
        if (s1_valid_q) begin
          out_pixel_q <= out_d;
        end
      end
    end
  end

  // Line buffers, window columns and sums carry no reset
  always_ff @(posedge fclk) begin
    if (acc) begin
      lb1_q[col_cur] <= lb0_q[col_cur];
      lb0_q[col_cur] <= s.in_pixel;
      t0_q    <= t1_q;
      m0_q    <= m1_q;
      b0_q    <= b1_q;
      t1_q    <= top2;
      m1_q    <= mid2;
      b1_q    <= bot2;
      s1_gx_q <= gx_d;
      s1_gy_q <= gy_d;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_pixel = out_pixel_q;
  assign s.out_last  = out_last_q;
endmodule

// File: tb/tb_sobel_stream_filter.sv
// tb/tb_sobel_stream_filter.sv - self-checking bench for sobel_stream_filter
// Two instances (SHIFT 3 and SHIFT 0) share one stimulus and a frame-level reference model.
module tb_sobel_stream_filter;
  localparam int W = 8;
  localparam int H = 6;
  localparam int P = 8;

  logic         fclk = 1'b0;
  logic         rst_n;
  logic [1:0]   mode;
  logic [P+2:0] threshold;
  logic         in_valid, in_sof, out_ready;
  logic [P-1:0] in_pixel;

  int errors = 0;
  int checks = 0;

  always #5 fclk = ~fclk;

  sobel_stream_filter_if #(.PIX_W(P)) if3 ();
  sobel_stream_filter_if #(.PIX_W(P)) if0 ();

  assign if3.in_valid  = in_valid;
  assign if3.in_pixel  = in_pixel;
  assign if3.in_sof    = in_sof;
  assign if3.out_ready = out_ready;
  assign if0.in_valid  = in_valid;
  assign if0.in_pixel  = in_pixel;
  assign if0.in_sof    = in_sof;
  assign if0.out_ready = out_ready;

  sobel_stream_filter #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .SHIFT(3)) u3 (
    .fclk(fclk), .rst_n(rst_n), .s(if3), .mode(mode), .threshold(threshold));
  sobel_stream_filter #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .SHIFT(0)) u0 (
    .fclk(fclk), .rst_n(rst_n), .s(if0), .mode(mode), .threshold(threshold));

  // Reference model: image array, raster position, latched mode, expected outputs
  int img [H][W];
  int mr, mc, mmode;
  int q3 [$];
  int q0 [$];
  int cnt3, cnt0, nz3, nz0;

  function automatic int pick(int gx, int gy, int md, int sh, int thr);
    int ax, ay, mag, v;
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    mag = ax + ay;
    if (md == 1) return (mag >= thr) ? 255 : 0;
    v = (md == 2) ? ax : (md == 3) ? ay : mag;
    v = v >> sh;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_accept(input int pix, input bit sof);
    int gx, gy, lst;
    int w [3][3];
    if (sof) begin
      mr = 0;
      mc = 0;
      mmode = int'(mode);
    end
    img[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[i][j] = img[mr-2+i][mc-2+j];
      gx  = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
      gy  = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
      lst = (mr == H-1 && mc == W-1) ? 256 : 0;
      q3.push_back(lst + pick(gx, gy, mmode, 3, int'(threshold)));
      q0.push_back(lst + pick(gx, gy, mmode, 0, int'(threshold)));
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end
  endtask

  always @(negedge fclk) begin
    int e, got;
    if (rst_n && out_ready && if3.out_valid) begin
      e   = (q3.size() > 0) ? q3.pop_front() : -1;
      got = int'({if3.out_last, if3.out_pixel});
      checks++;
      assert (got === e) else begin
        errors++;
        $error("FAIL out3 got=%0d expected=%0d (256=last)", got, e);
      end
      cnt3++;
      if (if3.out_pixel != 0) nz3++;
    end
  end

  always @(negedge fclk) begin
    int e, got;
    if (rst_n && out_ready && if0.out_valid) begin
      e   = (q0.size() > 0) ? q0.pop_front() : -1;
      got = int'({if0.out_last, if0.out_pixel});
      checks++;
      assert (got === e) else begin
        errors++;
        $error("FAIL out0 got=%0d expected=%0d (256=last)", got, e);
      end
      cnt0++;
      if (if0.out_pixel != 0) nz0++;
    end
  end

  task automatic cycle(input bit v, input int pix, input bit sof);
    @(posedge fclk);
    #1;
    in_valid = v;
    in_pixel = pix[7:0];
    in_sof   = sof;
    if (v && out_ready && rst_n) model_accept(pix, sof);
  endtask

  task automatic stall(input int n);
    logic [9:0] h3, h0;
    @(posedge fclk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pixel  = 8'hAA;
    in_sof    = 1'b0;
    h3 = {if3.out_valid, if3.out_last, if3.out_pixel};
    h0 = {if0.out_valid, if0.out_last, if0.out_pixel};
    for (int i = 0; i < n; i++) begin
      @(negedge fclk);
      checks++;
      assert ({if3.out_valid, if3.out_last, if3.out_pixel} === h3 && if3.in_ready === 1'b0) else begin
        errors++;
        $error("FAIL stall_hold3 got=%h in_ready=%b expected=%h in_ready=0",
               {if3.out_valid, if3.out_last, if3.out_pixel}, if3.in_ready, h3);
      end
      checks++;
      assert ({if0.out_valid, if0.out_last, if0.out_pixel} === h0 && if0.in_ready === 1'b0) else begin
        errors++;
        $error("FAIL stall_hold0 got=%h in_ready=%b expected=%h in_ready=0",
               {if0.out_valid, if0.out_last, if0.out_pixel}, if0.in_ready, h0);
      end
    end
    @(posedge fclk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
  endtask

  // kind: 0 flat 77, 1 step 0/100, 2 step 0/255, 3 random
  task automatic send_frame(input int kind, input int nrows, input int stall_at, input int chg_at);
    int pix, idx;
    idx = 0;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < W; c++) begin
        case (kind)
          0:       pix = 77;
          1:       pix = (c >= 4) ? 100 : 0;
          2:       pix = (c >= 4) ? 255 : 0;
          default: pix = int'($urandom_range(0, 255));
        endcase
        if (idx == stall_at) stall(5);
        if (idx == chg_at) mode = mode ^ 2'd1;
        if (kind == 3 && $urandom_range(0, 3) == 0) cycle(1'b0, 0, 1'b0);
        cycle(1'b1, pix, (r == 0 && c == 0));
        idx++;
      end
    end
    cycle(1'b0, 0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q3.size() > 0 || q0.size() > 0); i++) cycle(1'b0, 0, 1'b0);
    repeat (2) cycle(1'b0, 0, 1'b0);
    checks++;
    assert (q3.size() == 0 && q0.size() == 0) else begin
      errors++;
      $error("FAIL drain pending3=%0d pending0=%0d expected=0", q3.size(), q0.size());
    end
  endtask

  task automatic clear_counts();
    cnt3 = 0; cnt0 = 0; nz3 = 0; nz0 = 0;
  endtask

  task automatic check_count(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_pixel = '0; in_sof = 1'b0;
    mode = 2'd0; threshold = 11'd500;
    mr = 0; mc = 0; mmode = 0;
    clear_counts();
    repeat (3) @(posedge fclk);
    @(negedge fclk);
    check_count("reset_in_ready", int'(if3.in_ready), 0);
    check_count("reset_out3", int'({if3.out_valid, if3.out_last, if3.out_pixel}), 0);
    check_count("reset_out0", int'({if0.out_valid, if0.out_last, if0.out_pixel}), 0);
    @(posedge fclk);
    #1;
    rst_n = 1'b1;

    send_frame(0, H, -1, -1); drain();
    check_count("flat_count", cnt3, 24);
    check_count("flat_nonzero", nz3, 0);

    clear_counts();
    send_frame(1, H, -1, -1); drain();
    check_count("vstep_count", cnt3, 24);
    check_count("vstep_nonzero", nz3, 8);

    clear_counts();
    send_frame(2, H, -1, -1); drain();
    check_count("sat_nonzero0", nz0, 8);

    mode = 2'd1; threshold = 11'd500; clear_counts();
    send_frame(2, H, -1, -1); drain();
    check_count("thr_nonzero", nz3, 8);

    mode = 2'd0; clear_counts();
    send_frame(3, H, 20, -1); drain();
    check_count("stall_count3", cnt3, 24);
    check_count("stall_count0", cnt0, 24);

    mode = 2'd2; clear_counts();
    send_frame(3, H, -1, -1); drain();
    mode = 2'd3;
    send_frame(3, H, -1, -1); drain();
    check_count("abs_modes_count", cnt3, 48);

    mode = 2'd0; clear_counts();
    send_frame(3, 3, -1, -1);
    send_frame(3, H, -1, -1); drain();
    check_count("resync_count", cnt3, 30);

    mode = 2'd2; clear_counts();
    send_frame(3, H, -1, 25); drain();
    check_count("modechg_count", cnt3, 24);

    mode = 2'd0; threshold = 11'd300; clear_counts();
    send_frame(3, 4, -1, -1);
    @(posedge fclk);
    #1;
    rst_n = 1'b0; in_valid = 1'b0;
    q3.delete(); q0.delete();
    mr = 0; mc = 0; mmode = 0;
    @(posedge fclk);
    #1;
    rst_n = 1'b1;
    @(negedge fclk);
    check_count("midrst_valid_last3", int'({if3.out_valid, if3.out_last}), 0);
    check_count("midrst_valid_last0", int'({if0.out_valid, if0.out_last}), 0);
    clear_counts();
    mode = 2'd1;
    send_frame(3, H, -1, -1); drain();
    check_count("midrst_count", cnt3, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
